// File: rtl/fp_accum_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fp_accum_ctrl (with fp_arith)                                  |
// | Purpose  : Framed FP32 accumulate controller driving an FP add/sub unit  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

module fp_arith (
    input  logic [31:0] i_data_1,
    input  logic [31:0] i_data_2,
    input  logic        i_op_sel,
    input  logic        i_en,
    output logic [31:0] o_data
);
    logic              w_sgn_l, w_sgn_s;
    logic [7:0]        w_exp_l, w_exp_s, w_diff;
    logic [22:0]       w_frc_l, w_frc_s;
    logic [23:0]       w_man_l, w_man_s;
    logic [26:0]       w_ext_s, w_mask, w_align, w_norm;
    logic [27:0]       w_sum;
    logic [4:0]        w_msb;
    logic signed [9:0] w_exp_n, w_exp_f;
    logic              w_rnd;
    logic [24:0]       w_man_r;
    logic [22:0]       w_frac;
    logic [31:0]       w_res;

    // Zero/denormal inputs flush to zero; Inf/NaN are not produced upstream.
    always_comb begin
        if (i_data_1[30:0] >= i_data_2[30:0]) begin
            w_sgn_l = i_data_1[31];
            w_exp_l = i_data_1[30:23];
            w_frc_l = i_data_1[22:0];
            w_sgn_s = i_data_2[31] ^ i_op_sel;
            w_exp_s = i_data_2[30:23];
            w_frc_s = i_data_2[22:0];
        end else begin
            w_sgn_l = i_data_2[31] ^ i_op_sel;
            w_exp_l = i_data_2[30:23];
            w_frc_l = i_data_2[22:0];
            w_sgn_s = i_data_1[31];
            w_exp_s = i_data_1[30:23];
            w_frc_s = i_data_1[22:0];
        end
        w_man_l = (w_exp_l == 8'd0) ? 24'd0 : {1'b1, w_frc_l};
        w_man_s = (w_exp_s == 8'd0) ? 24'd0 : {1'b1, w_frc_s};
        w_diff  = w_exp_l - w_exp_s;

        // Align the smaller operand with guard/round/sticky bits.
        w_ext_s = {w_man_s, 3'b000};
        w_mask  = ~(27'h7FF_FFFF << w_diff);
        w_align = (w_ext_s >> w_diff) | {26'd0, |(w_ext_s & w_mask)};
        if (w_sgn_l == w_sgn_s)
            w_sum = {1'b0, w_man_l, 3'b000} + {1'b0, w_align};
        else
            w_sum = {1'b0, w_man_l, 3'b000} - {1'b0, w_align};

        w_msb = 5'd0;
        for (int i = 0; i < 28; i++) begin
            if (w_sum[i])
                w_msb = 5'(i);
        end
        w_exp_n = $signed({2'b00, w_exp_l}) + $signed({5'b00000, w_msb}) - 10'sd26;

        if (w_msb == 5'd27)
            w_norm = {w_sum[27:2], |w_sum[1:0]};
        else
            w_norm = w_sum[26:0] << (5'd26 - w_msb);

        // Round to nearest, ties to even.
        w_rnd   = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_man_r = {1'b0, w_norm[26:3]} + {24'd0, w_rnd};
        w_exp_f = w_exp_n + $signed({9'd0, w_man_r[24]});
        w_frac  = w_man_r[24] ? w_man_r[23:1] : w_man_r[22:0];

        if (w_sum == 28'd0)
            w_res = 32'd0;
        else if (w_exp_f >= 10'sd255)
            w_res = {w_sgn_l, 8'hFF, 23'd0};
        else if (w_exp_f <= 10'sd0)
            w_res = {w_sgn_l, 31'd0};
        else
            w_res = {w_sgn_l, w_exp_f[7:0], w_frac};

        o_data = i_en ? w_res : i_data_1;
    end
endmodule

module fp_accum_ctrl #(
    parameter int                 DATA_WIDTH = 32,
    parameter int                 CNT_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] ACCUM_INIT = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  op_sel_i,
    input  logic                  last_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic                  busy_o
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_op_data;
    logic                  r_op_sel;
    logic                  r_op_first;
    logic                  r_op_vld;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_fp_out;

    assign w_accept = valid_i & ready_o;

    fp_arith u_fp_arith (
        .i_data_1 (r_acc),
        .i_data_2 (r_op_data),
        .i_op_sel (r_op_sel),
        .i_en     (r_op_vld & ~r_op_first),
        .o_data   (w_fp_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = last_i ? S_FLUSH : S_ACCUM;
            S_ACCUM: if (w_accept && last_i) w_state_nxt = S_FLUSH;
            S_FLUSH: w_state_nxt = S_DONE;
            S_DONE:  if (result_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready_o        = (r_state == S_IDLE) || (r_state == S_ACCUM);
        busy_o         = (r_state != S_IDLE);
        result_valid_o = (r_state == S_DONE);
        result_o       = r_acc;
        count_o        = r_count;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= ACCUM_INIT;
            r_op_data  <= '0;
            r_op_sel   <= 1'b0;
            r_op_first <= 1'b0;
            r_op_vld   <= 1'b0;
            r_count    <= '0;
        end else begin
            r_op_vld <= w_accept;
            if (w_accept) begin
                r_op_data  <= data_i;
                r_op_sel   <= op_sel_i;
                r_op_first <= (r_state == S_IDLE);
                if (r_state == S_IDLE)
                    r_count <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                else if (!(&r_count))
                    r_count <= r_count + 1'b1;
            end
            // The first operand is loaded directly so the adder never sees ACCUM_INIT.
            if (r_state == S_DONE && result_ready_i) begin
                r_acc   <= ACCUM_INIT;
                r_count <= '0;
            end else if (r_op_vld) begin
                r_acc <= r_op_first ? r_op_data : w_fp_out;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fp_accum_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fp_accum_ctrl                                              |
// | Purpose  : Self-checking bench for fp_accum_ctrl with integer FP model   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fp_accum_ctrl;
    localparam int CW = 4;

    logic          clk, rst;
    logic [31:0]   data_i;
    logic          op_sel_i, last_i, valid_i, ready_o;
    logic [31:0]   result_o;
    logic [CW-1:0] count_o;
    logic          result_valid_o, result_ready_i, busy_o;

    int            vectors, errors;
    logic [31:0]   q_data[$];
    logic          q_sel[$];
    int            q_gap[$];
    logic          hold_vld;
    logic [31:0]   hold_data;

    fp_accum_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(CW), .ACCUM_INIT(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_i         (data_i),
        .op_sel_i       (op_sel_i),
        .last_i         (last_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .result_o       (result_o),
        .count_o        (count_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Exact FP32 encoding of an integer with magnitude below 2^24.
    function automatic logic [31:0] int2fp(input int v);
        int          m, p;
        logic [31:0] mm;
        if (v == 0) return 32'd0;
        m = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 31; i++) if ((m >> i) != 0) p = i;
        mm = 32'(m) << (23 - p);
        return {(v < 0), 8'(127 + p), mm[22:0]};
    endfunction

    task automatic push(input logic [31:0] d, input logic s, input int g);
        q_data.push_back(d);
        q_sel.push_back(s);
        q_gap.push_back(g);
    endtask

    task automatic clear_q();
        q_data.delete();
        q_sel.delete();
        q_gap.delete();
    endtask

    task automatic run_frame(input int rel_dly, input logic [31:0] exp_res, input int exp_cnt);
        int n;
        n = q_data.size();
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < q_gap[i]; g++) begin
                valid_i = 1'b0;
                @(posedge clk); #1;
                chk("busy_in_gap", 32'(busy_o), (i > 0) ? 32'd1 : 32'd0);
            end
            valid_i  = 1'b1;
            data_i   = q_data[i];
            op_sel_i = q_sel[i];
            last_i   = (i == n - 1);
            chk("ready_accept", 32'(ready_o), 32'd1);
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
        chk("flush_ready", 32'(ready_o), 32'd0);
        chk("flush_rvalid", 32'(result_valid_o), 32'd0);
        @(posedge clk); #1;
        chk("done_rvalid", 32'(result_valid_o), 32'd1);
        chk("result", result_o, exp_res);
        chk("count", 32'(count_o), 32'(exp_cnt));
        for (int d = 0; d < rel_dly; d++) begin
            if (hold_vld) begin
                valid_i  = 1'b1;
                data_i   = hold_data;
                op_sel_i = 1'b0;
            end
            @(posedge clk); #1;
            chk("hold_rvalid", 32'(result_valid_o), 32'd1);
            chk("hold_ready", 32'(ready_o), 32'd0);
            chk("hold_result", result_o, exp_res);
            chk("hold_count", 32'(count_o), 32'(exp_cnt));
        end
        result_ready_i = 1'b1;
        @(posedge clk); #1;
        result_ready_i = 1'b0;
        chk("idle_rvalid", 32'(result_valid_o), 32'd0);
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_ready", 32'(ready_o), 32'd1);
        chk("idle_result", result_o, 32'h0);
        chk("idle_count", 32'(count_o), 32'd0);
    endtask

    initial begin
        vectors = 0; errors = 0;
        hold_vld = 1'b0; hold_data = 32'h0;
        rst = 1'b1; data_i = 32'h0; op_sel_i = 1'b0; last_i = 1'b0;
        valid_i = 1'b0; result_ready_i = 1'b0;
        #1;
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_rvalid", 32'(result_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_result", result_o, 32'h0);
        chk("rst_count", 32'(count_o), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // 1.0 + 2.0
        clear_q(); push(32'h3F800000, 1'b0, 0); push(32'h40000000, 1'b0, 0);
        run_frame(0, 32'h40400000, 2);

        // Back-to-back 1+2+3, then hold DONE for 5 cycles with valid high
        clear_q(); push(32'h3F800000, 1'b0, 0); push(32'h40000000, 1'b0, 0);
        push(32'h40400000, 1'b0, 0);
        hold_vld = 1'b1; hold_data = 32'h40A00000;
        run_frame(5, 32'h40C00000, 3);
        hold_vld = 1'b0;

        // 5.0 - 2.0, first operand accepted right after release
        clear_q(); push(32'h40A00000, 1'b0, 0); push(32'h40000000, 1'b1, 0);
        run_frame(1, 32'h40400000, 2);

        // First operand with subtract selected loads unchanged
        clear_q(); push(32'h40A00000, 1'b1, 0);
        run_frame(0, 32'h40A00000, 1);

        clear_q(); push(32'hC0490FDB, 1'b0, 0);
        run_frame(0, 32'hC0490FDB, 1);

        // Counter saturates while accumulation continues: 20 x 1.0
        clear_q();
        for (int i = 0; i < 20; i++) push(32'h3F800000, 1'b0, 0);
        run_frame(0, int2fp(20), 15);

        // Reset after two operands of a frame
        valid_i = 1'b1; data_i = 32'h40000000; op_sel_i = 1'b0; last_i = 1'b0;
        @(posedge clk); #1;
        data_i = 32'h40400000;
        @(posedge clk); #1;
        valid_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(ready_o), 32'd1);
        chk("mid_rst_rvalid", 32'(result_valid_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_result", result_o, 32'h0);
        chk("mid_rst_count", 32'(count_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_q(); push(32'h3F800000, 1'b0, 0);
        run_frame(0, 32'h3F800000, 1);

        // Random integer-valued frames against the arithmetic model
        for (int f = 0; f < 16; f++) begin
            int   n, acc, v, g;
            logic s;
            clear_q();
            n   = int'($urandom_range(1, 8));
            acc = 0;
            for (int i = 0; i < n; i++) begin
                v = int'($urandom_range(1, 2000));
                if ($urandom_range(0, 1) == 1) v = -v;
                s = 1'($urandom_range(0, 1));
                if (i == 0) acc = v;
                else        acc = s ? (acc - v) : (acc + v);
                g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
                push(int2fp(v), s, g);
            end
            run_frame(int'($urandom_range(0, 2)), int2fp(acc), n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fp_accum_ctrl.md
# fp_accum_ctrl

Sequential accumulation controller that sits directly upstream of the floating-point add/subtract unit `fp_arith`. It accepts a valid/ready stream of IEEE-754 single-precision operands grouped into frames by a `last` marker. It drives one `fp_arith` instance with the running accumulator and the current operand, and registers the result back into the accumulator. At frame end it presents the final sum and the element count on a valid/ready result port.

## Interface

Parameters:

- `DATA_WIDTH`, 32, operand/result width (FP32 only).
- `CNT_WIDTH`, 16, element counter width.
- `ACCUM_INIT`, 32'h0000_0000, accumulator idle/reset value.

Ports:

- `clk`, input, 1, single clock, rising edge.
- `rst`, input, 1, asynchronous, active-high reset.
- `data_i`, input, DATA_WIDTH, FP32 operand.
- `op_sel_i`, input, 1, 0 = add, 1 = subtract (acc − data_i); sampled with `data_i`.
- `last_i`, input, 1, marks final operand of a frame.
- `valid_i`, input, 1, operand valid.
- `ready_o`, output, 1, operand accepted when `valid_i & ready_o`.
- `result_o`, output, DATA_WIDTH, final accumulator value.
- `count_o`, output, CNT_WIDTH, operands accepted in frame (saturating).
- `result_valid_o`, output, 1, result available.
- `result_ready_i`, input, 1, consumer accepts result.
- `busy_o`, output, 1, frame in progress (state ≠ IDLE).

## Operation

- Operand register `op_q` holds data, op_sel, first, last and vld. It is loaded on every accept.
- The accumulator register is `acc_q`.
- `fp_arith` is driven as follows: `data_1 = acc_q`, `data_2 = op_q.data`, `op_sel = op_q.op_sel`, `en = op_q.vld & ~op_q.first`.
- First operand of a frame: `acc_q <= op_q.data` (direct load). `fp_arith` assumes a normalised hidden bit and must never see `ACCUM_INIT`. Its `op_sel` is ignored.
- Subsequent operands: `acc_q <= fp_arith.data_o`.
- `count_q` increments on each accept and saturates at 2^CNT_WIDTH−1. It is reset to 0 when a new frame starts; the frame's first accept sets it to 1.

States:

- IDLE
  - `ready_o = 1`.
  - On accept: `op_q.first = 1`, `count_q = 1`.
  - Next state: FLUSH if `last_i`, else ACCUM.
- ACCUM
  - `ready_o = 1`.
  - On accept: `op_q.first = 0`, count increments.
  - On an accept with `last_i`, next state is FLUSH.
- FLUSH
  - `ready_o = 0`.
  - The pending `op_q` retires into `acc_q` this cycle.
  - Next state: DONE.
- DONE
  - `ready_o = 0`, `result_valid_o = 1`, `result_o = acc_q`, `count_o = count_q`.
  - On `result_ready_i`: → IDLE, `acc_q <= ACCUM_INIT`, `count_q <= 0`.
- With no accept in ACCUM, the state holds. `op_q.vld` clears after retiring, so `acc_q` holds.
- Subtraction applies as `acc − x`. Sign handling is entirely inside `fp_arith`.

## Timing

- Reset values (asynchronous): state = IDLE, `acc_q = ACCUM_INIT`, `op_q.vld = 0`, `count_q = 0`, `ready_o = 1`, `result_valid_o = 0`, `busy_o = 0`, `result_o = ACCUM_INIT`, `count_o = 0`.
- Throughput is one operand per clock within a frame. An operand accepted in cycle N is folded into `acc_q` at the end of cycle N+1.
- Latency: if the last operand is accepted in cycle N, `result_valid_o` rises in cycle N+2.
- Minimum frame-to-frame gap is 3 cycles: FLUSH, DONE (if `result_ready_i` is already high), then IDLE.
- `result_o` and `count_o` are stable while `result_valid_o & ~result_ready_i`.
- `valid_i` during FLUSH/DONE is not accepted. The upstream holds it.
- Single-operand frame (first & last): the result equals the operand bit-exactly, with `count_o = 1`.
- Reset mid-frame: the partial accumulation is discarded and no result is emitted. The first accept after reset starts a new frame.
- Counter saturation: `count_o` stays at its maximum value. Accumulation continues.

## Test plan

- Reset, then frame 3F800000 (1.0), 40000000 (2.0, last) as add → `result_o = 40400000` (3.0), `count_o = 2`, `result_valid_o` 2 cycles after last accept.
- Back-to-back valid for 3F800000, 40000000, 40400000 (last) → `ready_o` stays high for 3 cycles, then `result_o = 40C00000` (6.0), `count_o = 3`.
- Frame 40A00000 (5.0), then 40000000 with `op_sel_i = 1` (last) → `result_o = 40400000` (3.0). A first operand sent with `op_sel_i = 1` is loaded unchanged.
- Single-operand frame C0490FDB → `result_o = C0490FDB`, `count_o = 1`.
- Hold `result_ready_i = 0` for 5 cycles in DONE while `valid_i = 1` → `ready_o = 0`, outputs stable. Release → IDLE, next frame accepted the following cycle.
- Assert `rst` after 2 operands of a frame → all outputs at reset values. The next frame 3F800000 (last) yields `result_o = 3F800000`, `count_o = 1`.
